// File: rtl/i_decode_stage_if.sv
// Fetch/writeback side of the MIPS decode stage and its ID/EX outputs.
// master drives IF/ID and MEM/WB fields; slave is the decode stage.
interface i_decode_stage_if;
  logic [31:0] IF_ID_INSTR;
  logic [31:0] IF_ID_NPC;
  logic        EX_MEM_PCSrc;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_WriteReg;
  logic [31:0] MEM_WB_WriteData;
  logic        stall;
  logic [1:0]  ID_EX_WB;
  logic [2:0]  ID_EX_M;
  logic [3:0]  ID_EX_EX;
  logic [31:0] ID_EX_NPC;
  logic [31:0] ID_EX_RD1;
  logic [31:0] ID_EX_RD2;
  logic [31:0] ID_EX_SIGNEXT;
  logic [4:0]  ID_EX_RT;
  logic [4:0]  ID_EX_RD;

  modport master (
    output IF_ID_INSTR,
    output IF_ID_NPC,
    output EX_MEM_PCSrc,
    output MEM_WB_RegWrite,
    output MEM_WB_WriteReg,
    output MEM_WB_WriteData,
    input  stall,
    input  ID_EX_WB,
    input  ID_EX_M,
    input  ID_EX_EX,
    input  ID_EX_NPC,
    input  ID_EX_RD1,
    input  ID_EX_RD2,
    input  ID_EX_SIGNEXT,
    input  ID_EX_RT,
    input  ID_EX_RD
  );

  modport slave (
    input  IF_ID_INSTR,
    input  IF_ID_NPC,
    input  EX_MEM_PCSrc,
    input  MEM_WB_RegWrite,
    input  MEM_WB_WriteReg,
    input  MEM_WB_WriteData,
    output stall,
    output ID_EX_WB,
    output ID_EX_M,
    output ID_EX_EX,
    output ID_EX_NPC,
    output ID_EX_RD1,
    output ID_EX_RD2,
    output ID_EX_SIGNEXT,
    output ID_EX_RT,
    output ID_EX_RD
  );
endinterface

// File: rtl/i_decode_stage.sv
// MIPS ID stage: register file, control decode, load-use
// hazard / branch-flush bubble insertion and the ID/EX register.
module i_decode_stage #(
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  i_decode_stage_if.slave  bus
);

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t ex_d;

  logic [31:0] rf_q [NREGS];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] instr;

  assign instr = bus.IF_ID_INSTR;
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  logic        we;
  logic [4:0]  wr;
  logic [31:0] wdata;

  assign wr    = bus.MEM_WB_WriteReg;
  assign wdata = bus.MEM_WB_WriteData;
  assign we    = bus.MEM_WB_RegWrite
              && (wr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we) begin
      rf_q[wr] <= wdata;
    end
  end

  // Write-through: a read racing the writeback sees the new value.
  logic        rs_byp;
  logic        rt_byp;
  logic [31:0] rd1;
  logic [31:0] rd2;

  assign rs_byp = BYPASS && we && (wr == rs);
  assign rt_byp = BYPASS && we && (wr == rt);

  assign rd1 = (rs == 5'd0) ? '0
             : rs_byp ? wdata
             : rf_q[rs];
  assign rd2 = (rt == 5'd0) ? '0
             : rt_byp ? wdata
             : rf_q[rt];

  logic is_r;
  logic is_lw;
  logic is_sw;
  logic is_beq;

  assign is_r   = (op == 6'h00);
  assign is_lw  = (op == 6'h23);
  assign is_sw  = (op == 6'h2B);
  assign is_beq = (op == 6'h04);

  logic [1:0] c_wb;
  logic [2:0] c_m;
  logic [3:0] c_ex;

  always_comb begin
    c_wb = '0;
    c_m  = '0;
    c_ex = '0;
    unique case (1'b1)
      is_r: begin
        c_wb = 2'b10;
        c_ex = 4'b1100;
      end
      is_lw: begin
        c_wb = 2'b11;
        c_m  = 3'b010;
        c_ex = 4'b0001;
      end
      is_sw: begin
        c_m  = 3'b001;
        c_ex = 4'b0001;
      end
      is_beq: begin
        c_m  = 3'b100;
        c_ex = 4'b0010;
      end
      default: ;
    endcase
  end

  logic load_use;
  logic bubble;

  assign load_use = ex_q.m[1]
                 && (ex_q.rt != 5'd0)
                 && ((ex_q.rt == rs)
                  || (ex_q.rt == rt));

  assign bubble = load_use || bus.EX_MEM_PCSrc;

  always_comb begin
    ex_d      = '0;
    ex_d.npc  = bus.IF_ID_NPC;
    ex_d.rd1  = rd1;
    ex_d.rd2  = rd2;
    ex_d.sext = {{16{instr[15]}},
                 instr[15:0]};
    ex_d.rt   = rt;
    ex_d.rd   = rd;
    if (!bubble) begin
      ex_d.wb = c_wb;
      ex_d.m  = c_m;
      ex_d.ex = c_ex;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // A flush overrides the stall: the squashed slot is refetched anyway.
  assign bus.stall = load_use
                  && !bus.EX_MEM_PCSrc;

  assign bus.ID_EX_WB      = ex_q.wb;
  assign bus.ID_EX_M       = ex_q.m;
  assign bus.ID_EX_EX      = ex_q.ex;
  assign bus.ID_EX_NPC     = ex_q.npc;
  assign bus.ID_EX_RD1     = ex_q.rd1;
  assign bus.ID_EX_RD2     = ex_q.rd2;
  assign bus.ID_EX_SIGNEXT = ex_q.sext;
  assign bus.ID_EX_RT      = ex_q.rt;
  assign bus.ID_EX_RD      = ex_q.rd;

endmodule

// File: tb/tb_i_decode_stage.sv
// Bench for i_decode_stage: directed spot checks plus
// randomized traffic against a behavioural model.
module tb_i_decode_stage;

  logic clk;
  logic rst_n;
  logic chk_en;

  int n_tests;
  int n_fail;

  i_decode_stage_if bus();

  i_decode_stage #(
    .NREGS (32),
    .BYPASS(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what the ID/EX register and the register file must hold.
  logic [31:0] mrf [32];
  logic [1:0]  m_wb;
  logic [2:0]  m_m;
  logic [3:0]  m_ex;
  logic [31:0] m_npc;
  logic [31:0] m_rd1;
  logic [31:0] m_rd2;
  logic [31:0] m_se;
  logic [4:0]  m_rt;
  logic [4:0]  m_rd;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ctl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.MEM_WB_RegWrite && bus.MEM_WB_WriteReg == idx)
      return bus.MEM_WB_WriteData;
    return mrf[idx];
  endfunction

  function automatic logic m_load_use();
    logic [4:0] s;
    logic [4:0] t;
    s = bus.IF_ID_INSTR[25:21];
    t = bus.IF_ID_INSTR[20:16];
    return m_m[1] && m_rt != 0 && (m_rt == s || m_rt == t);
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    m_wb = '0; m_m = '0; m_ex = '0;
    m_npc = '0; m_rd1 = '0; m_rd2 = '0;
    m_se = '0; m_rt = '0; m_rd = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    logic [8:0]  c;
    logic [31:0] ins;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      m_wb = '0; m_m = '0; m_ex = '0;
      m_npc = '0; m_rd1 = '0; m_rd2 = '0;
      m_se = '0; m_rt = '0; m_rd = '0;
    end else begin
      ins = bus.IF_ID_INSTR;
      c = ctl_of(ins[31:26]);
      if (m_load_use() || bus.EX_MEM_PCSrc) c = '0;
      m_rd1 = mread(ins[25:21]);
      m_rd2 = mread(ins[20:16]);
      m_npc = bus.IF_ID_NPC;
      m_se  = 32'(signed'(ins[15:0]));
      m_rt  = ins[20:16];
      m_rd  = ins[15:11];
      m_wb  = c[8:7];
      m_m   = c[6:4];
      m_ex  = c[3:0];
      if (bus.MEM_WB_RegWrite && bus.MEM_WB_WriteReg != 0)
        mrf[bus.MEM_WB_WriteReg] = bus.MEM_WB_WriteData;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(bus.stall),
            32'(m_load_use() && !bus.EX_MEM_PCSrc));
      check("WB",   32'(bus.ID_EX_WB), 32'(m_wb));
      check("M",    32'(bus.ID_EX_M),  32'(m_m));
      check("EX",   32'(bus.ID_EX_EX), 32'(m_ex));
      check("NPC",  bus.ID_EX_NPC, m_npc);
      check("RD1",  bus.ID_EX_RD1, m_rd1);
      check("RD2",  bus.ID_EX_RD2, m_rd2);
      check("SEXT", bus.ID_EX_SIGNEXT, m_se);
      check("RT",   32'(bus.ID_EX_RT), 32'(m_rt));
      check("RD",   32'(bus.ID_EX_RD), 32'(m_rd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] r,
                    input logic [31:0] d);
    bus.MEM_WB_RegWrite  = en;
    bus.MEM_WB_WriteReg  = r;
    bus.MEM_WB_WriteData = d;
  endtask

  task automatic ctl_zero(input string tag);
    check({tag, "_WB"}, 32'(bus.ID_EX_WB), 32'd0);
    check({tag, "_M"},  32'(bus.ID_EX_M),  32'd0);
    check({tag, "_EX"}, 32'(bus.ID_EX_EX), 32'd0);
  endtask

  initial begin
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    rst_n   = 1'b1;
    bus.IF_ID_INSTR  = '0;
    bus.IF_ID_NPC    = '0;
    bus.EX_MEM_PCSrc = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    ctl_zero("rst");
    check("rst_RD1", bus.ID_EX_RD1, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    bus.IF_ID_INSTR = 32'h00A00000;
    tick();
    check("r5_RD1", bus.ID_EX_RD1, 32'd0);
    check("r5_WB", 32'(bus.ID_EX_WB), 32'h2);

    wb(1'b1, 5'd8, 32'hDEADBEEF);
    bus.IF_ID_INSTR = 32'h0;
    tick();
    wb(1'b0, 5'd0, 32'd0);
    bus.IF_ID_INSTR = 32'h01095020;
    tick();
    check("add_RD1", bus.ID_EX_RD1, 32'hDEADBEEF);
    check("add_WB", 32'(bus.ID_EX_WB), 32'h2);
    check("add_EX", 32'(bus.ID_EX_EX), 32'hC);
    check("add_RD", 32'(bus.ID_EX_RD), 32'd10);
    wb(1'b1, 5'd8, 32'h13572468);
    tick();
    check("byp_RD1", bus.ID_EX_RD1, 32'h13572468);

    wb(1'b1, 5'd0, 32'h1234);
    bus.IF_ID_INSTR = 32'h0;
    tick();
    check("r0_byp", bus.ID_EX_RD1, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    check("r0_rd", bus.ID_EX_RD1, 32'd0);
    bus.IF_ID_INSTR = 32'h8C0AFFFC;
    tick();
    check("lw_SEXT", bus.ID_EX_SIGNEXT, 32'hFFFFFFFC);
    check("lw_M", 32'(bus.ID_EX_M), 32'h2);
    check("lw_WB", 32'(bus.ID_EX_WB), 32'h3);

    bus.IF_ID_INSTR = 32'h014B6020;
    #1 check("lu_stall", 32'(bus.stall), 32'd1);
    tick();
    ctl_zero("lu_bub");
    check("lu_stall0", 32'(bus.stall), 32'd0);
    tick();
    check("lu_WB", 32'(bus.ID_EX_WB), 32'h2);
    check("lu_EX", 32'(bus.ID_EX_EX), 32'hC);
    check("lu_RD", 32'(bus.ID_EX_RD), 32'd12);

    bus.IF_ID_INSTR = 32'h8C0AFFFC;
    tick();
    bus.IF_ID_INSTR  = 32'h10000003;
    bus.EX_MEM_PCSrc = 1'b1;
    #1 check("fl_stall", 32'(bus.stall), 32'd0);
    tick();
    ctl_zero("fl");
    bus.EX_MEM_PCSrc = 1'b0;
    bus.IF_ID_INSTR  = 32'h8C0AFFFC;
    tick();
    bus.IF_ID_INSTR  = 32'h014B6020;
    bus.EX_MEM_PCSrc = 1'b1;
    #1 check("fllu_stall", 32'(bus.stall), 32'd0);
    tick();
    ctl_zero("fllu");
    bus.EX_MEM_PCSrc = 1'b0;
    bus.IF_ID_INSTR  = 32'h10000003;
    tick();
    check("beq_M", 32'(bus.ID_EX_M), 32'h4);
    check("beq_EX", 32'(bus.ID_EX_EX), 32'h2);

    bus.IF_ID_INSTR = 32'hFC000000;
    bus.IF_ID_NPC   = 32'h14;
    tick();
    ctl_zero("unk");
    check("unk_NPC", bus.ID_EX_NPC, 32'h14);

    wb(1'b1, 5'd5, 32'h55555555);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    ctl_zero("mid");
    check("mid_RD1", bus.ID_EX_RD1, 32'd0);
    check("mid_NPC", bus.ID_EX_NPC, 32'd0);
    check("mid_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.IF_ID_INSTR = 32'h00A00000;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_r5", bus.ID_EX_RD1, 32'd0);
    check("post_WB", 32'(bus.ID_EX_WB), 32'h2);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h23;
        3: op = 6'h2B;
        4: op = 6'h04;
        default: op = 6'($urandom);
      endcase
      rs = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                        : 5'($urandom_range(0, 3));
      rt = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                        : 5'($urandom_range(0, 3));
      bus.IF_ID_INSTR  = {op, rs, rt, 16'($urandom)};
      bus.IF_ID_NPC    = $urandom;
      bus.EX_MEM_PCSrc = ($urandom_range(0, 7) == 0);
      wb(1'($urandom),
         ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                      : 5'($urandom_range(0, 3)),
         $urandom);
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
